// File: rtl/trig_request_arbiter.sv
// Round-robin arbiter sharing one sin/cos unit between NUM_REQ requesters.
// Tags ride a fixed-latency shift register to route results back.
module trig_request_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_REQ      = 3,
    parameter int TRIG_LATENCY = 20,
    parameter int TAG_WIDTH    = 3
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_phase_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    output logic [DATA_WIDTH-1:0]         trig_phase_out,
    output logic                          trig_phase_valid_out,
    input  logic [DATA_WIDTH-1:0]         trig_sin_in,
    input  logic [DATA_WIDTH-1:0]         trig_cos_in,
    input  logic                          trig_valid_in,
    output logic [DATA_WIDTH-1:0]         resp_sin_out,
    output logic [DATA_WIDTH-1:0]         resp_cos_out,
    output logic [NUM_REQ-1:0]            resp_valid_out,
    output logic                          sync_error_out
);

    logic [TAG_WIDTH-1:0]  ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    gnt;
    logic [TAG_WIDTH-1:0]  gnt_idx;
    logic                  gnt_any;
    logic [DATA_WIDTH-1:0] gnt_phase;

    logic [DATA_WIDTH-1:0] phase_q, phase_d;
    logic                  pvalid_q, pvalid_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;

    logic [TRIG_LATENCY-1:0]                slot_v_q, slot_v_d;
    logic [TRIG_LATENCY-1:0][TAG_WIDTH-1:0] slot_tag_q, slot_tag_d;
    logic                                   out_v;
    logic [TAG_WIDTH-1:0]                   out_tag;

    logic [DATA_WIDTH-1:0] rsin_q, rsin_d;
    logic [DATA_WIDTH-1:0] rcos_q, rcos_d;
    logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
    logic                  err_q, err_d;

    // Grant the first valid requester at or after the pointer, wrapping.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        gnt_phase = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_any && req_valid_in[i] &&
                    ((int'(ptr_q) + k) % NUM_REQ == i)) begin
                    gnt_any   = 1'b1;
                    gnt[i]    = 1'b1;
                    gnt_idx   = TAG_WIDTH'(i);
                    gnt_phase = req_phase_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Issue stage: register the granted phase and advance the pointer.
    always_comb begin
        ptr_d    = ptr_q;
        phase_d  = phase_q;
        tag_d    = tag_q;
        pvalid_d = gnt_any;
        if (gnt_any) begin
            ptr_d   = (gnt_idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0
                                                           : gnt_idx + TAG_WIDTH'(1);
            phase_d = gnt_phase;
            tag_d   = gnt_idx;
        end
    end

    // Tag pipeline: output slot lines up with the unit's result strobe.
    always_comb begin
        slot_v_d   = {slot_v_q[TRIG_LATENCY-2:0], pvalid_q};
        slot_tag_d = {slot_tag_q[TRIG_LATENCY-2:0], tag_q};
    end

    assign out_v   = slot_v_q[TRIG_LATENCY-1];
    assign out_tag = slot_tag_q[TRIG_LATENCY-1];

    // Route matched results to their owner; flag any slot/result mismatch.
    always_comb begin
        rvalid_d = '0;
        rsin_d   = rsin_q;
        rcos_d   = rcos_q;
        err_d    = err_q;
        if (trig_valid_in && out_v) begin
            rsin_d = trig_sin_in;
            rcos_d = trig_cos_in;
            for (int i = 0; i < NUM_REQ; i++) begin
                rvalid_d[i] = (out_tag == TAG_WIDTH'(i));
            end
        end
        if (trig_valid_in != out_v) begin
            err_d = 1'b1;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            phase_q    <= '0;
            pvalid_q   <= 1'b0;
            tag_q      <= '0;
            slot_v_q   <= '0;
            slot_tag_q <= '0;
            rsin_q     <= '0;
            rcos_q     <= '0;
            rvalid_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            phase_q    <= phase_d;
            pvalid_q   <= pvalid_d;
            tag_q      <= tag_d;
            slot_v_q   <= slot_v_d;
            slot_tag_q <= slot_tag_d;
            rsin_q     <= rsin_d;
            rcos_q     <= rcos_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
        end
    end

    assign req_ready_out        = gnt;
    assign trig_phase_out       = phase_q;
    assign trig_phase_valid_out = pvalid_q;
    assign resp_sin_out         = rsin_q;
    assign resp_cos_out         = rcos_q;
    assign resp_valid_out       = rvalid_q;
    assign sync_error_out       = err_q;

endmodule
